scaler_channel_reader: RTL and testbench

SCALER_CHANNEL_READER -- requirements
Module: scaler_channel_reader

---
 rtl/scaler_channel_reader.sv | 140 ++++++++++++++
 tb/tb_scaler_channel_reader.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_channel_reader.sv
// Reads a 28-bit scaler time sample as two 14-bit halves, re-reading the low half
// until the high half is stable across the low-half read or the retry limit is hit.
//
// state | meaning
// IDLE  | waiting for REQ
// RDB1  | first strobe of the high half (CHBT)
// RDA   | strobe of the low half (CHAT)
// RDB2  | second strobe of the high half, coherence reference
// CHECK | one-cycle verdict; finish or go back to RDA
module scaler_channel_reader #(
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic        CLOCK,
    input  logic        rst,
    input  logic        REQ,
    input  logic [13:0] CHAT,
    input  logic [13:0] CHBT,
    output logic        RCHAT_,
    output logic        RCHBT_,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [27:0] TIME
);
    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {IDLE, RDB1, RDA, RDB2, CHECK} state_t;

    state_t        state, state_n;
    logic [2:0]    cnt, cnt_n;
    logic [RW-1:0] retry, retry_n, retry_inc;
    logic [13:0]   b1, b1_n, a, a_n, b2, b2_n;
    logic          match;
    logic          done_n, err_n, busy_n, rchat_n, rchbt_n;
    logic [27:0]   time_n;

    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            retry  <= '0;
            b1     <= '0;
            a      <= '0;
            b2     <= '0;
            RCHAT_ <= 1'b1;
            RCHBT_ <= 1'b1;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            ERR    <= 1'b0;
            TIME   <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            retry  <= retry_n;
            b1     <= b1_n;
            a      <= a_n;
            b2     <= b2_n;
            RCHAT_ <= rchat_n;
            RCHBT_ <= rchbt_n;
            BUSY   <= busy_n;
            DONE   <= done_n;
            ERR    <= err_n;
            TIME   <= time_n;
        end
    end

    // Read windows use a down-counter: strobe low while cnt != 0, capture at cnt == 1,
    // and the cnt == 0 cycle is the gap. The verdict is formed on the edge into CHECK
    // so DONE/ERR/TIME are already valid during the CHECK cycle.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        retry_n   = retry;
        b1_n      = b1;
        a_n       = a;
        b2_n      = b2;
        done_n    = 1'b0;
        err_n     = ERR;
        time_n    = TIME;
        retry_inc = retry + 1'b1;
        match     = (b1 == b2);

        case (state)
            IDLE: begin
                if (REQ) begin
                    state_n = RDB1;
                    cnt_n   = 3'(SETTLE);
                    retry_n = '0;
                end
            end
            RDB1: begin
                if (cnt == 3'd1) b1_n = CHBT;
                if (cnt == 3'd0) begin
                    state_n = RDA;
                    cnt_n   = 3'(SETTLE);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RDA: begin
                if (cnt == 3'd1) a_n = CHAT;
                if (cnt == 3'd0) begin
                    state_n = RDB2;
                    cnt_n   = 3'(SETTLE);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RDB2: begin
                if (cnt == 3'd1) b2_n = CHBT;
                if (cnt == 3'd0) begin
                    state_n = CHECK;
                    if (!match) retry_n = retry_inc;
                    if (match || (retry_inc == RW'(MAX_RETRY))) begin
                        done_n = 1'b1;
                        err_n  = !match;
                        time_n = {b2, a};
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            CHECK: begin
                if (DONE) begin
                    state_n = IDLE;
                end else begin
                    state_n = RDA;
                    cnt_n   = 3'(SETTLE);
                    b1_n    = b2;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n  = (state_n != IDLE);
        rchbt_n = !(((state_n == RDB1) || (state_n == RDB2)) && (cnt_n != 3'd0));
        rchat_n = !((state_n == RDA) && (cnt_n != 3'd0));
    end
endmodule

// File: tb/tb_scaler_channel_reader.sv
// Self-checking bench for scaler_channel_reader: per-cycle bus tables driven against
// a window-schedule model of the read/retry sequence.
module tb_scaler_channel_reader;
    localparam int S  = 2;
    localparam int MR = 3;

    logic        CLOCK = 1'b0;
    logic        rst   = 1'b1;
    logic        REQ   = 1'b0;
    logic [13:0] CHAT  = '0;
    logic [13:0] CHBT  = '0;
    logic        RCHAT_, RCHBT_, BUSY, DONE, ERR;
    logic [27:0] TIME;

    scaler_channel_reader #(.SETTLE(S), .MAX_RETRY(MR)) dut (
        .CLOCK (CLOCK),
        .rst   (rst),
        .REQ   (REQ),
        .CHAT  (CHAT),
        .CHBT  (CHBT),
        .RCHAT_(RCHAT_),
        .RCHBT_(RCHBT_),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ERR   (ERR),
        .TIME  (TIME)
    );

    always #5 CLOCK = ~CLOCK;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge CLOCK) cyc++;

    // bus value presented during cycle c (cycle 0 = accepting cycle)
    logic [13:0] bus_a [64];
    logic [13:0] bus_b [64];
    logic [27:0] prev_time = '0;
    logic        prev_err  = 1'b0;
    int          exp_done;
    logic        exp_err;
    logic [27:0] exp_time;
    int          a_starts[$];
    int          b_starts[$];
    int          done_cyc;

    always @(negedge CLOCK) begin
        checks++;
        assert (RCHAT_ || RCHBT_) else begin
            fails++;
            $display("FAIL strobe_overlap cyc=%0d RCHAT_=%b RCHBT_=%b required not both 0", cyc, RCHAT_, RCHBT_);
        end
    end

    // Schedule of read windows: B1, then (A, B2, check) repeated until B1==B2 or MR mismatches.
    task automatic build_model();
        int t, retries;
        logic [13:0] b1, b2, a;
        a_starts.delete();
        b_starts.delete();
        t = 1;
        b_starts.push_back(t);
        b1 = bus_b[t+S-1];
        t += S + 1;
        retries = 0;
        exp_done = 0;
        b2 = '0;
        a = '0;
        while (exp_done == 0) begin
            a_starts.push_back(t);
            a = bus_a[t+S-1];
            t += S + 1;
            b_starts.push_back(t);
            b2 = bus_b[t+S-1];
            t += S + 1;
            if (b1 == b2) begin
                exp_done = t;
                exp_err  = 1'b0;
            end else begin
                retries++;
                if (retries == MR) begin
                    exp_done = t;
                    exp_err  = 1'b1;
                end else begin
                    b1 = b2;
                    t += 1;
                end
            end
        end
        exp_time = {b2, a};
    endtask

    task automatic run_sample(input bit hold, output int lat);
        logic        exp_ra, exp_rb;
        logic [27:0] et;
        logic        ee;
        build_model();
        lat = -1;
        @(negedge CLOCK);
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            fails++;
            $display("FAIL idle_before_req BUSY=%b DONE=%b required 0 0", BUSY, DONE);
        end
        REQ  = 1'b1;
        CHAT = bus_a[0];
        CHBT = bus_b[0];
        for (int c = 1; c <= exp_done; c++) begin
            @(negedge CLOCK);
            exp_rb = 1'b1;
            exp_ra = 1'b1;
            foreach (b_starts[i]) if (c >= b_starts[i] && c < b_starts[i] + S) exp_rb = 1'b0;
            foreach (a_starts[i]) if (c >= a_starts[i] && c < a_starts[i] + S) exp_ra = 1'b0;
            et = (c < exp_done) ? prev_time : exp_time;
            ee = (c < exp_done) ? prev_err : exp_err;
            checks++;
            if (RCHBT_ !== exp_rb) begin
                fails++;
                $display("FAIL rchbt c=%0d got=%b exp=%b", c, RCHBT_, exp_rb);
            end
            checks++;
            if (RCHAT_ !== exp_ra) begin
                fails++;
                $display("FAIL rchat c=%0d got=%b exp=%b", c, RCHAT_, exp_ra);
            end
            checks++;
            if (BUSY !== 1'b1) begin
                fails++;
                $display("FAIL busy c=%0d got=%b exp=1", c, BUSY);
            end
            checks++;
            if (DONE !== logic'(c == exp_done)) begin
                fails++;
                $display("FAIL done c=%0d got=%b exp=%b", c, DONE, c == exp_done);
            end
            checks++;
            if (TIME !== et) begin
                fails++;
                $display("FAIL time c=%0d got=%h exp=%h", c, TIME, et);
            end
            checks++;
            if (ERR !== ee) begin
                fails++;
                $display("FAIL err c=%0d got=%b exp=%b", c, ERR, ee);
            end
            if (DONE === 1'b1 && lat < 0) lat = c;
            if (c == exp_done) done_cyc = cyc;
            REQ  = hold ? 1'b1 : ((c < exp_done) ? 1'($urandom_range(0, 1)) : 1'b0);
            CHAT = bus_a[c];
            CHBT = bus_b[c];
        end
        prev_time = exp_time;
        prev_err  = exp_err;
    endtask

    task automatic fill_static(input logic [13:0] hb, input logic [13:0] lb);
        for (int c = 0; c < 64; c++) begin
            bus_b[c] = hb;
            bus_a[c] = lb;
        end
    endtask

    task automatic test_reset();
        @(negedge CLOCK);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({RCHAT_, RCHBT_, BUSY, DONE, ERR} !== 5'b11000 || TIME !== 28'h0) begin
            fails++;
            $display("FAIL reset_values got RCHAT_=%b RCHBT_=%b BUSY=%b DONE=%b ERR=%b TIME=%h exp 1 1 0 0 0 0",
                     RCHAT_, RCHBT_, BUSY, DONE, ERR, TIME);
        end
        repeat (2) @(negedge CLOCK);
        rst = 1'b1;
        prev_time = '0;
        prev_err  = 1'b0;
    endtask

    task automatic test_static();
        int lat;
        fill_static(14'h0123, 14'h2ABC);
        run_sample(1'b0, lat);
        checks++;
        if (lat !== 10) begin
            fails++;
            $display("FAIL static_latency got=%0d exp=10", lat);
        end
        checks++;
        if (TIME !== 28'h048EABC || ERR !== 1'b0) begin
            fails++;
            $display("FAIL static_time got=%h/%b exp=048eabc/0", TIME, ERR);
        end
    endtask

    task automatic test_rollover();
        int lat;
        for (int c = 0; c < 64; c++) begin
            bus_b[c] = (c <= S + 1) ? 14'h0005 : 14'h0006;
            bus_a[c] = (c <= S + 1) ? 14'h3FFF : 14'h0000;
        end
        run_sample(1'b0, lat);
        checks++;
        if (lat !== 17) begin
            fails++;
            $display("FAIL rollover_latency got=%0d exp=17", lat);
        end
        checks++;
        if (TIME !== 28'h0018000 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL rollover_time got=%h/%b exp=0018000/0", TIME, ERR);
        end
    endtask

    task automatic test_unstable();
        int lat, n;
        logic [13:0] base, lo;
        base = 14'h0100;
        lo   = 14'h1234;
        for (int c = 0; c < 64; c++) begin
            n = 0;
            for (int k = 0; k < MR; k++) if (c >= 2*(S+1) + 1 + k*(2*(S+1)+1)) n++;
            bus_b[c] = base + 14'(n);
            bus_a[c] = lo;
        end
        run_sample(1'b0, lat);
        checks++;
        if (lat !== 24) begin
            fails++;
            $display("FAIL unstable_latency got=%0d exp=24", lat);
        end
        checks++;
        if (TIME !== {base + 14'd3, lo} || ERR !== 1'b1) begin
            fails++;
            $display("FAIL unstable_time got=%h/%b exp=%h/1", TIME, ERR, {base + 14'd3, lo});
        end
    endtask

    task automatic test_random();
        int lat;
        logic [13:0] hb;
        for (int it = 0; it < 20; it++) begin
            hb = 14'($urandom);
            for (int c = 0; c < 64; c++) begin
                if ($urandom_range(0, 5) == 0) hb = hb + 14'd1;
                bus_b[c] = hb;
                bus_a[c] = 14'($urandom);
            end
            run_sample(1'b0, lat);
        end
    endtask

    task automatic test_abort();
        int lat;
        fill_static(14'h1111, 14'h2222);
        @(negedge CLOCK);
        REQ  = 1'b1;
        CHAT = 14'h2222;
        CHBT = 14'h1111;
        @(negedge CLOCK);
        REQ = 1'b0;
        repeat (S + 1) @(negedge CLOCK);
        checks++;
        if (RCHAT_ !== 1'b0) begin
            fails++;
            $display("FAIL abort_in_rda RCHAT_ got=%b exp=0", RCHAT_);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({RCHAT_, RCHBT_, BUSY, DONE, ERR} !== 5'b11000 || TIME !== 28'h0) begin
            fails++;
            $display("FAIL abort_values got RCHAT_=%b RCHBT_=%b BUSY=%b DONE=%b ERR=%b TIME=%h exp 1 1 0 0 0 0",
                     RCHAT_, RCHBT_, BUSY, DONE, ERR, TIME);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK);
            checks++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                fails++;
                $display("FAIL abort_hold i=%0d DONE=%b BUSY=%b exp 0 0", i, DONE, BUSY);
            end
        end
        rst = 1'b1;
        prev_time = '0;
        prev_err  = 1'b0;
        fill_static(14'h0ACE, 14'h3210);
        run_sample(1'b0, lat);
        checks++;
        if (TIME !== {14'h0ACE, 14'h3210} || lat !== 10) begin
            fails++;
            $display("FAIL abort_recover got=%h lat=%0d exp=%h lat=10", TIME, lat, {14'h0ACE, 14'h3210});
        end
    endtask

    task automatic test_back_to_back();
        int lat, d0;
        fill_static(14'h2001, 14'h0F0F);
        run_sample(1'b1, lat);
        d0 = done_cyc;
        for (int k = 0; k < 2; k++) begin
            fill_static(14'(k + 7), 14'($urandom));
            run_sample(1'b1, lat);
            checks++;
            if (done_cyc - d0 !== 11) begin
                fails++;
                $display("FAIL back_to_back_spacing k=%0d got=%0d exp=11", k, done_cyc - d0);
            end
            d0 = done_cyc;
        end
        REQ = 1'b0;
    endtask

    initial begin
        test_reset();
        test_static();
        test_rollover();
        test_unstable();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
